// File: rtl/bcd_scan_ctrl_if.sv
// rtl/bcd_scan_ctrl_if.sv - CPU store/load path into the 7-segment scan controller
interface bcd_scan_ctrl_if;
    logic [31:0] WBwritadress;
    logic [31:0] WBwritdata;
    logic        BCDWrite;
    logic        BCDRead;
    logic [31:0] BCD_Read_data;

    modport master (
        output WBwritadress,
        output WBwritdata,
        output BCDWrite,
        output BCDRead,
        input  BCD_Read_data
    );

    modport slave (
        input  WBwritadress,
        input  WBwritdata,
        input  BCDWrite,
        input  BCDRead,
        output BCD_Read_data
    );
endinterface

// File: rtl/bcd_scan_ctrl.sv
// rtl/bcd_scan_ctrl.sv - 4-digit common-anode 7-segment scan controller with frame-committed registers
// Optional leading-zero suppression: BCD_LEADING_ZERO_BLANK_EN
module bcd_scan_ctrl #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter logic [31:0] BASE_ADDR = 32'h40000010
) (
    input  logic            clk,
    input  logic            reset,
    bcd_scan_ctrl_if.slave  bus,
    output logic [11:0]     digi
);
    localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [31:0] ADDR_VAL = BASE_ADDR;
    localparam logic [31:0] ADDR_CTL = BASE_ADDR + 32'd4;
    localparam logic [31:0] ADDR_STS = BASE_ADDR + 32'd8;

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      val_s_q, val_s_d, val_a_q, val_a_d;
    logic [11:0]      ctl_s_q, ctl_s_d, ctl_a_q, ctl_a_d;
    logic [11:0]      digi_q, digi_d;
    logic [31:0]      rdata_q, rdata_d;

    logic       tick, commit, pending, lz_blank;
    logic       hit_val, hit_ctl, hit_sts;
    logic [3:0] nib, blank_a, dp_a;
    logic [6:0] seg;

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 7'h40;
            4'h1: hex_seg = 7'h79;
            4'h2: hex_seg = 7'h24;
            4'h3: hex_seg = 7'h30;
            4'h4: hex_seg = 7'h19;
            4'h5: hex_seg = 7'h12;
            4'h6: hex_seg = 7'h02;
            4'h7: hex_seg = 7'h78;
            4'h8: hex_seg = 7'h00;
            4'h9: hex_seg = 7'h10;
            4'hA: hex_seg = 7'h08;
            4'hB: hex_seg = 7'h03;
            4'hC: hex_seg = 7'h46;
            4'hD: hex_seg = 7'h21;
            4'hE: hex_seg = 7'h06;
            default: hex_seg = 7'h0E;
        endcase
    endfunction

`ifdef BCD_LEADING_ZERO_BLANK_EN
    // A slot is dark when it and every more-significant nibble are zero.
    always_comb begin
        case (idx_q)
            2'd3:    lz_blank = (val_a_q[15:12] == 4'h0);
            2'd2:    lz_blank = (val_a_q[15:8]  == 8'h00);
            2'd1:    lz_blank = (val_a_q[15:4]  == 12'h000);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    assign blank_a = ctl_a_q[7:4];
    assign dp_a    = ctl_a_q[11:8];
    assign nib     = val_a_q[{idx_q, 2'b00} +: 4];
    assign seg     = hex_seg(nib);

    assign hit_val = (bus.WBwritadress == ADDR_VAL);
    assign hit_ctl = (bus.WBwritadress == ADDR_CTL);
    assign hit_sts = (bus.WBwritadress == ADDR_STS);

    assign tick    = (div_q == DIV_LAST);
    // While disabled the active copy tracks staging so enabling shows fresh data.
    assign commit  = (tick && (idx_q == 2'd3)) || !ctl_a_q[0];
    assign pending = (val_s_q != val_a_q) || (ctl_s_q != ctl_a_q);

    always_comb begin
        div_d   = tick ? '0 : div_q + 1'b1;
        idx_d   = tick ? idx_q + 2'd1 : idx_q;
        val_s_d = val_s_q;
        ctl_s_d = ctl_s_q;
        val_a_d = commit ? val_s_q : val_a_q;
        ctl_a_d = commit ? ctl_s_q : ctl_a_q;
        rdata_d = rdata_q;

        if (bus.BCDWrite) begin
            if (hit_val) val_s_d = bus.WBwritdata[15:0];
            if (hit_ctl) ctl_s_d = {bus.WBwritdata[11:4], 3'b000, bus.WBwritdata[0]};
        end else if (bus.BCDRead) begin
            if (hit_val)      rdata_d = {16'h0000, val_s_q};
            else if (hit_ctl) rdata_d = {20'h00000, ctl_s_q[11:4], 3'b000, ctl_s_q[0]};
            else if (hit_sts) rdata_d = {29'h0, idx_q, pending};
            else              rdata_d = 32'h0;
        end

        if (!ctl_a_q[0] || blank_a[idx_q] || lz_blank) begin
            digi_d = 12'hFFF;
        end else begin
            digi_d = {~(4'b0001 << idx_q), ~dp_a[idx_q], seg};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            idx_q   <= 2'd0;
            val_s_q <= 16'h0000;
            val_a_q <= 16'h0000;
            ctl_s_q <= 12'h000;
            ctl_a_q <= 12'h000;
            digi_q  <= 12'hFFF;
            rdata_q <= 32'h0;
        end else begin
            div_q   <= div_d;
            idx_q   <= idx_d;
            val_s_q <= val_s_d;
            val_a_q <= val_a_d;
            ctl_s_q <= ctl_s_d;
            ctl_a_q <= ctl_a_d;
            digi_q  <= digi_d;
            rdata_q <= rdata_d;
        end
    end

    assign digi              = digi_q;
    assign bus.BCD_Read_data = rdata_q;
endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// tb/tb_bcd_scan_ctrl.sv - directed self-checking bench for bcd_scan_ctrl with SCAN_DIV=4
module tb_bcd_scan_ctrl;
    localparam logic [31:0] A_VAL = 32'h40000010;
    localparam logic [31:0] A_CTL = 32'h40000014;
    localparam logic [31:0] A_STS = 32'h40000018;
    localparam logic [31:0] A_BAD = 32'h40000020;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] digi;
    int          tests = 0;
    int          failed = 0;
    int          cyc = 0;

    bcd_scan_ctrl_if bus ();

    bcd_scan_ctrl #(.SCAN_DIV(4), .BASE_ADDR(32'h40000010)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .digi  (digi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.WBwritadress = addr;
        bus.WBwritdata   = data;
        bus.BCDWrite     = 1'b1;
        step();
        bus.BCDWrite     = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr);
        bus.WBwritadress = addr;
        bus.BCDRead      = 1'b1;
        step();
        bus.BCDRead      = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        bus.WBwritadress = 32'h0;
        bus.WBwritdata   = 32'h0;
        bus.BCDWrite     = 1'b0;
        bus.BCDRead      = 1'b0;
        step();
        step();
        chk("reset_digi", {20'h0, digi}, 32'hFFF);
        chk("reset_rdata", bus.BCD_Read_data, 32'h0);
        reset = 1'b0;
        cyc = 0;

        wr(A_VAL, 32'h1234);
        wr(A_CTL, 32'h1);
        idle_to(4);  chk("scan_d0", {20'h0, digi}, 32'hE99);
        idle_to(5);  chk("scan_d1_first", {20'h0, digi}, 32'hDB0);
        idle_to(8);  chk("scan_d1_last", {20'h0, digi}, 32'hDB0);
        idle_to(9);  chk("scan_d2", {20'h0, digi}, 32'hBA4);
        idle_to(13); chk("scan_d3", {20'h0, digi}, 32'h7F9);
        idle_to(17); chk("scan_d0_again", {20'h0, digi}, 32'hE99);

        wr(A_VAL, 32'hABCD);
        rd(A_STS);
        chk("status_pending", bus.BCD_Read_data, 32'h1);
        chk("no_tear_d0", {20'h0, digi}, 32'hE99);
        idle_to(32); chk("no_tear_d3", {20'h0, digi}, 32'h7F9);
        idle_to(33); chk("commit_d0", {20'h0, digi}, 32'hEA1);
        idle_to(36);
        rd(A_STS);
        chk("status_cleared_idx1", bus.BCD_Read_data, 32'h2);

        wr(A_CTL, 32'h0F01);
        wr(A_VAL, 32'h8888);
        rd(A_CTL);   chk("read_ctl", bus.BCD_Read_data, 32'hF01);
        rd(A_VAL);   chk("read_val", bus.BCD_Read_data, 32'h8888);
        idle_to(49); chk("dp_d0", {20'h0, digi}, 32'hE00);
        idle_to(53); chk("dp_d1", {20'h0, digi}, 32'hD00);
        idle_to(57); chk("dp_d2", {20'h0, digi}, 32'hB00);
        idle_to(61); chk("dp_d3", {20'h0, digi}, 32'h700);

        wr(A_CTL, 32'h0021);
        idle_to(65); chk("blank_d0", {20'h0, digi}, 32'hE80);
        idle_to(69); chk("blank_d1", {20'h0, digi}, 32'hFFF);
        idle_to(73); chk("blank_d2", {20'h0, digi}, 32'hB80);
        idle_to(77); chk("blank_d3", {20'h0, digi}, 32'h780);

        bus.WBwritadress = A_VAL;
        bus.WBwritdata   = 32'h5555;
        bus.BCDWrite     = 1'b1;
        bus.BCDRead      = 1'b1;
        step();
        bus.BCDWrite     = 1'b0;
        bus.BCDRead      = 1'b0;
        chk("wr_rd_holds", bus.BCD_Read_data, 32'h8888);
        rd(A_VAL);   chk("wr_rd_wrote", bus.BCD_Read_data, 32'h5555);
        rd(A_BAD);   chk("read_unmapped", bus.BCD_Read_data, 32'h0);
        wr(A_STS, 32'hFFFF);
        wr(A_BAD, 32'h1111);
        rd(A_VAL);   chk("ignored_writes_val", bus.BCD_Read_data, 32'h5555);
        rd(A_CTL);   chk("ignored_writes_ctl", bus.BCD_Read_data, 32'h021);

        reset = 1'b1;
        step();
        chk("midreset_digi", {20'h0, digi}, 32'hFFF);
        chk("midreset_rdata", bus.BCD_Read_data, 32'h0);
        reset = 1'b0;
        cyc = 0;
        rd(A_VAL);   chk("midreset_val_dropped", bus.BCD_Read_data, 32'h0);
        idle_to(5);
        rd(A_STS);   chk("midreset_idx_restart", bus.BCD_Read_data, 32'h2);

        wr(A_CTL, 32'h1);
        chk("enable_lat0", {20'h0, digi}, 32'hFFF);
        step();
        chk("enable_lat1", {20'h0, digi}, 32'hFFF);
        step();
        chk("enable_lat2", {20'h0, digi}, 32'hBC0);

        wr(A_VAL, 32'h0042);
        idle_to(17); chk("lz42_d0", {20'h0, digi}, 32'hEA4);
        idle_to(21); chk("lz42_d1", {20'h0, digi}, 32'hD99);
`ifdef BCD_LEADING_ZERO_BLANK_EN
        idle_to(25); chk("lz42_d2", {20'h0, digi}, 32'hFFF);
        idle_to(29); chk("lz42_d3", {20'h0, digi}, 32'hFFF);
`else
        idle_to(25); chk("lz42_d2", {20'h0, digi}, 32'hBC0);
        idle_to(29); chk("lz42_d3", {20'h0, digi}, 32'h7C0);
`endif
        wr(A_VAL, 32'h0);
        idle_to(33); chk("lz0_d0", {20'h0, digi}, 32'hEC0);
`ifdef BCD_LEADING_ZERO_BLANK_EN
        idle_to(37); chk("lz0_d1", {20'h0, digi}, 32'hFFF);
`else
        idle_to(37); chk("lz0_d1", {20'h0, digi}, 32'hDC0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
